// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus for the fetch sequencer.
//   req   : fetch request, held with addr until ack
//   addr  : fetch address
//   ack   : request complete, rdata valid this cycle (may coincide with req)
//   rdata : fetched instruction
// master = fetch controller, slave = instruction memory.
interface if_fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input  ack, rdata);
    modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer for the 5-stage pipeline. It owns the fetch PC,
// drives the imem handshake and produces pc/instr plus stall/flush for IF/ID.
// Ports:
//   clk_i, rst_n_i         clock, async active-low reset
//   hazard_stall_i         load-use stall, IF/ID must hold
//   redirect_i/_pc_i       taken branch/jump from ID and its target
//   imem (master)          req/addr out, ack/rdata in
//   pc_o, instr_o          IF/ID pc and instruction inputs
//   ifid_stall_o/_flush_o  IF/ID controls
//   bubble_cnt_o           saturating count of fetch-starved bubbles
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   hazard_stall_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    if_fetch_ctrl_if.master        imem,
    output logic [31:0]            pc_o,
    output logic [31:0]            instr_o,
    output logic                   ifid_stall_o,
    output logic                   ifid_flush_o,
    output logic [15:0]            bubble_cnt_o
);

    typedef enum logic [1:0] {ST_START, ST_FETCH, ST_DROP, ST_HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        deliver;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        bubble_cnt_d = bubble_cnt_q;
        imem.req     = 1'b0;
        imem.addr    = pc_q;
        deliver      = 1'b0;
        pc_o         = pc_q;
        instr_o      = 32'h0;
        ifid_stall_o = 1'b0;
        ifid_flush_o = 1'b0;

        case (state_q)
            ST_START: state_d = ST_FETCH;
            ST_FETCH: begin
                imem.req = 1'b1;
                if (imem.ack) begin
                    if (redirect_i) begin
                        // Fetched word is on the wrong path; drop it.
                        pc_d = redirect_pc_i;
                    end else begin
                        pc_d = pc_q + 32'd4;
                        if (hazard_stall_i) begin
                            // IF/ID is frozen; park the word until it can move.
                            buf_pc_d    = pc_q;
                            buf_instr_d = imem.rdata;
                            state_d     = ST_HOLD;
                        end else begin
                            deliver = 1'b1;
                            instr_o = imem.rdata;
                        end
                    end
                end else if (redirect_i) begin
                    // Request can't be withdrawn; keep it on the bus until ack.
                    drop_addr_d = pc_q;
                    pc_d        = redirect_pc_i;
                    state_d     = ST_DROP;
                end
            end
            ST_DROP: begin
                imem.req  = 1'b1;
                imem.addr = drop_addr_q;
                if (redirect_i) pc_d = redirect_pc_i;
                if (imem.ack)   state_d = ST_FETCH;
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = ST_FETCH;
                end else if (!hazard_stall_i) begin
                    deliver = 1'b1;
                    pc_o    = buf_pc_q;
                    instr_o = buf_instr_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_START;
        endcase

        if (redirect_i) begin
            ifid_flush_o = 1'b1;
        end else if (hazard_stall_i) begin
            ifid_stall_o = 1'b1;
        end else if (!deliver) begin
            ifid_flush_o = 1'b1;
            // The post-reset cycle is a bubble but not a starved one.
            if (state_q != ST_START && bubble_cnt_q != 16'hFFFF)
                bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_START;
            pc_q         <= RESET_PC;
            drop_addr_q  <= 32'h0;
            buf_pc_q     <= 32'h0;
            buf_instr_q  <= 32'h0;
            bubble_cnt_q <= 16'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hz = 1'b0, rd = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] pc_o, instr_o;
    logic        stall, flush;
    logic [15:0] bcnt;

    if_fetch_ctrl_if imem();

    if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .hazard_stall_i(hz), .redirect_i(rd),
        .redirect_pc_i(rpc), .imem(imem.master), .pc_o(pc_o), .instr_o(instr_o),
        .ifid_stall_o(stall), .ifid_flush_o(flush), .bubble_cnt_o(bcnt)
    );

    always #5 clk = ~clk;

    int nvec = 0, nfail = 0;

    // Reference model: where the fetcher stands in terms of the rules
    bit          m_start;        // post-reset cycle
    logic [31:0] m_pc;           // next PC to fetch
    bit          m_disc;         // an abandoned request is still on the bus
    logic [31:0] m_daddr;
    ent_t        m_held[$];      // instruction parked while IF/ID stalls
    int          m_bub;
    // Memory responder
    int          w_lo = 0, w_hi = 0;
    bit          never_ack = 0;
    bit          mem_busy;
    int          mem_left;
    // Last observed IF/ID outputs
    logic [31:0] obs_pc, obs_ins;
    logic        obs_st, obs_fl;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_start = 1; m_pc = RESET_PC; m_disc = 0; m_daddr = 0;
        m_held.delete(); m_bub = 0; mem_busy = 0; mem_left = 0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cyc(input bit h, input bit r, input logic [31:0] t);
        bit e_req, a, dlv, e_st, e_fl;
        logic [31:0] e_addr, e_pc, e_ins;
        ent_t e;
        e_req  = !m_start && m_held.size() == 0;
        e_addr = m_disc ? m_daddr : m_pc;
        a = 0;
        if (e_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_left = never_ack ? (1 << 30) : int'($urandom_range(w_hi, w_lo));
            end
            if (mem_left == 0) begin a = 1; mem_busy = 0; end
            else mem_left--;
        end
        hz = h; rd = r; rpc = t;
        imem.ack = a; imem.rdata = a ? data_of(e_addr) : $urandom();
        @(negedge clk);
        dlv   = !r && !h && ((e_req && !m_disc && a) || m_held.size() != 0);
        e_pc  = m_pc; e_ins = 32'h0;
        if (dlv) begin
            if (m_held.size() != 0) begin e_pc = m_held[0].pc; e_ins = m_held[0].ins; end
            else e_ins = data_of(m_pc);
        end
        e_fl = r || (!h && !dlv);
        e_st = !r && h;
        obs_pc = pc_o; obs_ins = instr_o; obs_st = stall; obs_fl = flush;
        nvec++; if (imem.req !== e_req)  begin nfail++; $display("FAIL req: got %b want %b t=%0t", imem.req, e_req, $time); end
        if (e_req) begin
            nvec++; if (imem.addr !== e_addr) begin nfail++; $display("FAIL addr: got %h want %h t=%0t", imem.addr, e_addr, $time); end
        end
        nvec++; if (pc_o !== e_pc)    begin nfail++; $display("FAIL pc_o: got %h want %h t=%0t", pc_o, e_pc, $time); end
        nvec++; if (instr_o !== e_ins) begin nfail++; $display("FAIL instr_o: got %h want %h t=%0t", instr_o, e_ins, $time); end
        nvec++; if (stall !== e_st)   begin nfail++; $display("FAIL stall: got %b want %b t=%0t", stall, e_st, $time); end
        nvec++; if (flush !== e_fl)   begin nfail++; $display("FAIL flush: got %b want %b t=%0t", flush, e_fl, $time); end
        nvec++; if (bcnt !== 16'(m_bub)) begin nfail++; $display("FAIL bubble_cnt: got %0d want %0d t=%0t", bcnt, m_bub, $time); end
        // advance the model
        if (!r && !h && !dlv && !m_start && m_bub < 65535) m_bub++;
        if (m_start) m_start = 0;
        else if (m_held.size() != 0) begin
            if (r) begin m_held.delete(); m_pc = t; end
            else if (!h) m_held.delete();
        end else if (m_disc) begin
            if (r) m_pc = t;
            if (a) m_disc = 0;
        end else if (a) begin
            if (r) m_pc = t;
            else begin
                if (h) begin e.pc = m_pc; e.ins = data_of(m_pc); m_held.push_back(e); end
                m_pc = m_pc + 32'd4;
            end
        end else if (r) begin
            m_disc = 1; m_daddr = m_pc; m_pc = t;
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 0; hz = 0; rd = 0; imem.ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 0; hz = 0; rd = 0; imem.ack = 0; imem.rdata = 32'hDEAD_BEEF;
        model_reset();
        #2;
        nvec++; if (imem.req !== 1'b0)     begin nfail++; $display("FAIL rst_req: got %b want 0", imem.req); end
        nvec++; if (imem.addr !== RESET_PC) begin nfail++; $display("FAIL rst_addr: got %h want %h", imem.addr, RESET_PC); end
        nvec++; if (pc_o !== RESET_PC)     begin nfail++; $display("FAIL rst_pc: got %h want %h", pc_o, RESET_PC); end
        nvec++; if (instr_o !== 32'h0)     begin nfail++; $display("FAIL rst_instr: got %h want 0", instr_o); end
        nvec++; if (stall !== 1'b0)        begin nfail++; $display("FAIL rst_stall: got %b want 0", stall); end
        nvec++; if (flush !== 1'b1)        begin nfail++; $display("FAIL rst_flush: got %b want 1", flush); end
        nvec++; if (bcnt !== 16'h0)        begin nfail++; $display("FAIL rst_bcnt: got %0d want 0", bcnt); end
        @(posedge clk); #1 rst_n = 1;
        w_lo = 0; w_hi = 0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
    endtask

    task automatic test_zero_wait();
        apply_reset(); w_lo = 0; w_hi = 0;
        cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0);
            nvec++; if (obs_pc !== 32'(i * 4) || obs_st !== 1'b0 || obs_fl !== 1'b0) begin
                nfail++; $display("FAIL zw_deliver: got pc %h st %b fl %b want pc %h st 0 fl 0", obs_pc, obs_st, obs_fl, i * 4);
            end
        end
        nvec++; if (bcnt !== 16'h0) begin nfail++; $display("FAIL zw_bcnt: got %0d want 0", bcnt); end
    endtask

    task automatic test_wait2();
        apply_reset(); w_lo = 2; w_hi = 2;
        cyc(0, 0, 0);
        repeat (9) cyc(0, 0, 0);
        nvec++; if (bcnt !== 16'd6) begin nfail++; $display("FAIL w2_bcnt: got %0d want 6", bcnt); end
        nvec++; if (imem.addr !== 32'd12) begin nfail++; $display("FAIL w2_addr: got %h want c", imem.addr); end
    endtask

    task automatic test_hazard();
        apply_reset(); w_lo = 0; w_hi = 0;
        cyc(0, 0, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            nvec++; if (obs_st !== 1'b1) begin nfail++; $display("FAIL hz_stall%0d: got %b want 1", i, obs_st); end
            nvec++; if (imem.req !== 1'b0) begin nfail++; $display("FAIL hz_hold_req%0d: got %b want 0", i, imem.req); end
        end
        cyc(0, 0, 0);
        nvec++; if (obs_pc !== 32'd8 || obs_ins !== data_of(32'd8)) begin
            nfail++; $display("FAIL hz_deliver: got %h/%h want 8/%h", obs_pc, obs_ins, data_of(32'd8));
        end
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'd12) begin
            nfail++; $display("FAIL hz_next: got req %b addr %h want 1 c", imem.req, imem.addr);
        end
    endtask

    task automatic test_redirect_drop();
        apply_reset(); w_lo = 0; w_hi = 0;
        cyc(0, 0, 0);
        repeat (8) cyc(0, 0, 0);
        w_lo = 2; w_hi = 2;
        cyc(0, 1, 32'h100);
        nvec++; if (obs_fl !== 1'b1) begin nfail++; $display("FAIL rd_flush: got %b want 1", obs_fl); end
        w_lo = 0; w_hi = 0;
        for (int i = 0; i < 2; i++) begin
            nvec++; if (imem.addr !== 32'h20) begin nfail++; $display("FAIL rd_drop_addr: got %h want 20", imem.addr); end
            cyc(0, 0, 0);
        end
        nvec++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin
            nfail++; $display("FAIL rd_target: got req %b addr %h want 1 100", imem.req, imem.addr);
        end
        cyc(0, 0, 0);
        nvec++; if (obs_pc !== 32'h100) begin nfail++; $display("FAIL rd_deliver: got %h want 100", obs_pc); end
    endtask

    task automatic test_redirect_hold();
        apply_reset(); w_lo = 0; w_hi = 0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 32'hFFFF_FFFC);
        nvec++; if (obs_fl !== 1'b1 || obs_st !== 1'b0) begin
            nfail++; $display("FAIL rh_ctrl: got fl %b st %b want 1 0", obs_fl, obs_st);
        end
        nvec++; if (imem.addr !== 32'hFFFF_FFFC) begin nfail++; $display("FAIL rh_target: got %h want fffffffc", imem.addr); end
        cyc(0, 0, 0);
        nvec++; if (imem.addr !== 32'h0) begin nfail++; $display("FAIL rh_wrap: got %h want 0", imem.addr); end
        cyc(0, 0, 0);
    endtask

    task automatic test_random();
        apply_reset(); w_lo = 0; w_hi = 3;
        cyc(0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(255, 0)) << 2;
            cyc($urandom_range(3, 0) == 0, $urandom_range(99, 0) < 15, t);
        end
    endtask

    task automatic test_saturate();
        apply_reset(); never_ack = 1;
        cyc(0, 0, 0);
        repeat (70000) cyc(0, 0, 0);
        nvec++; if (bcnt !== 16'hFFFF) begin nfail++; $display("FAIL sat_bcnt: got %h want ffff", bcnt); end
        #2 rst_n = 0; imem.ack = 0;
        model_reset();
        #1;
        nvec++; if (imem.req !== 1'b0) begin nfail++; $display("FAIL midrst_req: got %b want 0", imem.req); end
        nvec++; if (bcnt !== 16'h0) begin nfail++; $display("FAIL midrst_bcnt: got %h want 0", bcnt); end
        never_ack = 0; w_lo = 0; w_hi = 0;
        @(posedge clk); #1 rst_n = 1;
        cyc(0, 0, 0);
        nvec++; if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin
            nfail++; $display("FAIL midrst_first: got req %b addr %h want 1 %h", imem.req, imem.addr, RESET_PC);
        end
        cyc(0, 0, 0);
    endtask

    initial begin
        imem.ack = 0; imem.rdata = 0;
        model_reset();
        test_reset();
        test_zero_wait();
        test_wait2();
        test_hazard();
        test_redirect_drop();
        test_redirect_hold();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
